// File: rtl/img_stream_pkg.sv
// Shared types for the raster pixel-stream source: FSM states and the per-pixel
// sideband that travels alongside each frame RAM read.
package img_stream_pkg;

    localparam int unsigned DEF_COORD_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
        logic                   sof;
        logic                   eol;
        logic                   eof;
    } sideband_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO used as the output skid buffer; entry0 is always the head.
module stream_skid2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;

    // Head only changes on a pop or on a push into an empty buffer, so it holds during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) entry0 <= din;
                    else             entry1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end else begin
                        entry0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = entry0;

endmodule

// File: rtl/img_stream_gen.sv
// Raster pixel-stream source: replays a frame RAM with sof/eol/eof, x/y and blanking.
// Optional test-pattern input tpg_mode is enabled by defining IMG_STREAM_GEN_TPG_EN.
module img_stream_gen
    import img_stream_pkg::*;
#(
    parameter int unsigned IMG_COL     = 30,
    parameter int unsigned IMG_ROW     = 20,
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned COORD_W     = DEF_COORD_W,
    parameter int unsigned H_BLANK     = 4,
    parameter int unsigned V_BLANK     = 8,
    parameter int unsigned ADDR_W      = $clog2(IMG_COL*IMG_ROW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [15:0]            num_frames,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [PIXEL_WIDTH-1:0] rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic [COORD_W-1:0]     x_coord,
    output logic [COORD_W-1:0]     y_coord,
    output logic                   busy,
    output logic                   frame_done
`ifdef IMG_STREAM_GEN_TPG_EN
    ,
    input  logic [1:0]             tpg_mode
`endif
);

    localparam int unsigned BLANK_W = 16;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned PAY_W   = $bits(sideband_t) + PIXEL_WIDTH;
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(IMG_COL - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(IMG_ROW - 1);

    if (COORD_W > DEF_COORD_W) begin : g_coord_w_check
        $error("img_stream_gen: COORD_W exceeds sideband coordinate width");
    end

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BLANK_W-1:0]   blank_q, blank_d;
    logic [FRAME_W-1:0]   frame_q, frame_d, nf_q, nf_d;
    logic                 issue_c, vblank_c, frame_end_c, room_c, pop_c;
    sideband_t            sb_d1, head_sb;
    logic                 vld_d1;
    logic [PIXEL_WIDTH-1:0] pix_c, head_px;
    logic [PAY_W-1:0]     head_w;
    logic [1:0]           occ;

    // Issue credit counts the head leaving this cycle, which sustains one pixel per clock.
    assign pop_c  = out_valid && out_ready;
    assign room_c = (3'({1'b0, occ}) - 3'(pop_c) + 3'(vld_d1)) < 3'd2;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        blank_d     = blank_q;
        frame_d     = frame_q;
        nf_d        = nf_q;
        issue_c     = 1'b0;
        vblank_c    = 1'b0;
        frame_end_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nf_d    = num_frames;
                    frame_d = '0;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    blank_d = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (room_c) begin
                    issue_c = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    x_d     = x_q + COORD_W'(1);
                    blank_d = '0;
                    if (x_q == LAST_X) begin
                        x_d = '0;
                        y_d = y_q + COORD_W'(1);
                        if (y_q == LAST_Y) begin
                            y_d    = '0;
                            addr_d = '0;
                        end
                        if (H_BLANK != 0)         state_d  = HBLANK;
                        else if (y_q == LAST_Y)   vblank_c = 1'b1;
                    end
                end
            end
            HBLANK: begin
                blank_d = blank_q + BLANK_W'(1);
                if (blank_q == BLANK_W'(H_BLANK - 1)) begin
                    blank_d = '0;
                    // y has already wrapped to 0 only after the last row of the frame
                    if (y_q == '0) vblank_c = 1'b1;
                    else           state_d  = ACTIVE;
                end
            end
            VBLANK: begin
                blank_d = blank_q + BLANK_W'(1);
                if (blank_q == BLANK_W'(V_BLANK - 1)) frame_end_c = 1'b1;
            end
            DRAIN: begin
                if (occ == 2'd0 && !vld_d1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (vblank_c) begin
            if (V_BLANK != 0) state_d     = VBLANK;
            else              frame_end_c = 1'b1;
        end
        if (frame_end_c) begin
            frame_d = frame_q + FRAME_W'(1);
            blank_d = '0;
            state_d = ((frame_d == nf_q && nf_q != '0) || stop) ? DRAIN : ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            blank_q    <= '0;
            frame_q    <= '0;
            nf_q       <= '0;
            vld_d1     <= 1'b0;
            sb_d1      <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            blank_q    <= blank_d;
            frame_q    <= frame_d;
            nf_q       <= nf_d;
            vld_d1     <= issue_c;
            frame_done <= pop_c && head_sb.eof;
            if (issue_c) begin
                sb_d1.x   <= DEF_COORD_W'(x_q);
                sb_d1.y   <= DEF_COORD_W'(y_q);
                sb_d1.sof <= (x_q == '0) && (y_q == '0);
                sb_d1.eol <= (x_q == LAST_X);
                sb_d1.eof <= (x_q == LAST_X) && (y_q == LAST_Y);
            end
        end
    end

`ifdef IMG_STREAM_GEN_TPG_EN
    assign rd_en = issue_c && (tpg_mode == 2'd0);

    always_comb begin
        pix_c = rd_data;
        case (tpg_mode)
            2'd1:    pix_c = PIXEL_WIDTH'(sb_d1.x);
            2'd2:    pix_c = (sb_d1.x[2] ^ sb_d1.y[2]) ? '1 : '0;
            2'd3:    pix_c = PIXEL_WIDTH'(1) << (PIXEL_WIDTH - 1);
            default: pix_c = rd_data;
        endcase
    end
`else
    assign rd_en = issue_c;
    assign pix_c = rd_data;
`endif

    stream_skid2 #(.W(PAY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (vld_d1),
        .din  ({sb_d1, pix_c}),
        .pop  (pop_c),
        .dout (head_w),
        .occ  (occ)
    );

    assign {head_sb, head_px} = head_w;
    assign rd_addr   = addr_q;
    assign out_valid = (occ != 2'd0);
    assign out_data  = head_px;
    assign out_sof   = head_sb.sof;
    assign out_eol   = head_sb.eol;
    assign out_eof   = head_sb.eof;
    assign x_coord   = COORD_W'(head_sb.x);
    assign y_coord   = COORD_W'(head_sb.y);
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/img_stream_gen.md
Name: img_stream_gen

Overview:
- Parametrised raster pixel-stream source that replaces ad-hoc pixel replay for the FAST/NMS pipeline.
- Reads a stored grey image from a synchronous frame RAM and emits it in raster order with valid/ready handshake.
- Generates sof/eol/eof flags, x/y coordinates, configurable horizontal/vertical blanking and a programmable frame count.
- Sits in front of FAST_with_NMS in the top level and drives its data_in/ce, both in simulation and on hardware.

Parameters:
- IMG_COL, 30: pixels per row, at least 2.
- IMG_ROW, 20: rows per frame, at least 2.
- PIXEL_WIDTH, 8: pixel bit width.
- COORD_W, 10: x/y coordinate width; requires IMG_COL and IMG_ROW to be at most 2**COORD_W.
- H_BLANK, 4: idle cycles inserted after each row; 0 is allowed.
- V_BLANK, 8: idle cycles inserted after each frame, in addition to the last row's H_BLANK; 0 is allowed.
- ADDR_W, $clog2(IMG_COL*IMG_ROW): frame RAM address width.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- stop  in  1  level; request to end after the current frame.
- num_frames  in  16  frames to send; 0 means continuous; latched on start.
- rd_en  out  1  frame RAM read enable.
- rd_addr  out  ADDR_W  read address, equal to y*IMG_COL+x.
- rd_data  in  PIXEL_WIDTH  RAM data, valid 1 cycle after rd_en.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accept.
- out_data  out  PIXEL_WIDTH  pixel.
- out_sof  out  1  marks pixel (0,0).
- out_eol  out  1  marks x==IMG_COL-1.
- out_eof  out  1  marks the last pixel of a frame.
- x_coord  out  COORD_W  pixel column.
- y_coord  out  COORD_W  pixel row.
- busy  out  1  high whenever not in IDLE.
- frame_done  out  1  one-cycle pulse when the eof pixel is accepted.

Behaviour:
- Reset:
  - Every output is 0, state is IDLE, counters are cleared and the skid buffer is empty.
  - Asserting rst mid-frame aborts immediately; no partial pixel is presented after reset.
- States: IDLE, ACTIVE, HBLANK, VBLANK, DRAIN.
- IDLE:
  - start=1 latches num_frames, clears x/y and moves to ACTIVE.
- ACTIVE:
  - Issues one read per cycle (rd_en=1) when skid occupancy plus in-flight reads is less than 2.
  - x increments on each issued read.
  - After issuing x==IMG_COL-1: x clears, y increments, go to HBLANK (or straight to next-row ACTIVE if H_BLANK==0).
  - After issuing the last pixel (x==IMG_COL-1, y==IMG_ROW-1): go to VBLANK after H_BLANK cycles.
- HBLANK / VBLANK:
  - Free-running cycle counters; no reads are issued.
  - The counters run regardless of out_ready.
  - Backpressure stalls only the issue point, never the blanking count.
- End of VBLANK:
  - Frame counter increments.
  - Go to DRAIN if the counter equals the latched num_frames (and num_frames is not 0), or if stop=1 is sampled at the end of VBLANK.
  - Otherwise go back to ACTIVE with x=y=0.
  - stop asserted mid-frame never truncates the frame.
- DRAIN:
  - Wait until the skid buffer is empty and no read is in flight, then go to IDLE.
- start is ignored outside IDLE.
- Sideband data:
  - x/y and the sof/eol/eof flags travel with each read through a 1-cycle delay register, then into a 2-entry skid FIFO together with rd_data.
  - out_* is driven from the skid FIFO head.
- Handshake:
  - A transfer happens when out_valid and out_ready are both 1.
  - While stalled, out_valid and every out_* signal stay stable.
  - out_valid never drops without a transfer.
- Latency:
  - The start pulse is in cycle 0.
  - rd_en=1 with rd_addr=0 in cycle 1.
  - out_valid=1 with the (0,0) pixel in cycle 3.
  - With out_ready held high, throughput is 1 pixel per clock inside a row.
- The skid FIFO never overflows: issue is gated as described above. Simultaneous push and pop is allowed.
- frame_done pulses in the cycle after the eof transfer.

Optional Feature:
- Macro: IMG_STREAM_GEN_TPG_EN. When defined, an extra input tpg_mode (2 bits) is added:
  - 0: RAM data.
  - 1: horizontal ramp, out_data = x truncated to PIXEL_WIDTH.
  - 2: checkerboard of 4x4 blocks, 0 or max value.
  - 3: constant 8'h80, scaled to PIXEL_WIDTH.
- In TPG modes 1–3, rd_en stays 0 and timing is identical to RAM mode.
- When the macro is undefined, the port is absent and data always comes from the RAM.

Decomposition:
- Package img_stream_pkg holds:
  - the state enum (IDLE/ACTIVE/HBLANK/VBLANK/DRAIN);
  - the sideband struct (x, y, sof, eol, eof);
  - the default COORD_W.
- Sub-module stream_skid2: a 2-entry FIFO with occupancy output, parametrised on payload width.

Test Plan:
- IMG_COL=4, IMG_ROW=3, H_BLANK=2, V_BLANK=3, out_ready=1, num_frames=1, RAM[a]=a:
  - Expect 12 pixels with data 0..11; sof on data 0; eol on 3, 7 and 11; eof on 11.
  - First out_valid 3 cycles after start; 2 idle cycles between rows.
  - frame_done pulses once, then busy=0.
- Same setup with out_ready toggled in a random 50% pattern:
  - Identical sequence of data and flags, no pixel lost or duplicated.
  - out_data stays stable during every stall.
- num_frames=0, then stop asserted in the middle of frame 2:
  - Frame 2 completes fully (eof is seen), then IDLE.
  - Exactly 2 frame_done pulses.
- rst asserted while at pixel (2,1):
  - All outputs are 0 in the same cycle.
  - A new start produces the (0,0) pixel with sof set.
- start pulsed while busy: ignored; the frame count is unchanged.
- With IMG_STREAM_GEN_TPG_EN defined and tpg_mode=1, IMG_COL=30:
  - x_coord matches out_data on every pixel; rd_en never asserts.
